// File: rtl/inst_decoder.sv
// ---------------------------------------------------------------------------
// inst_decoder
//
// Decode/issue stage that sits directly after the fetch unit. The instruction
// word comes from synchronous memory, so it arrives one cycle after its PC.
// This block does four things:
//   - drives PC-redirect controls back to fetch (call, return, jump, hold)
//   - issues execute-class opcodes to the datapath through a 1-cycle register
//   - tracks call depth against the fetch return stack
//   - handles stall (WAIT), halt and the branch-shadow flush slot
//
// Build option:
//   DEC_COND_JMP_EN  when defined, opcode 6 (JZ) jumps if zero_flag_i=1 and is
//                    a NOP otherwise. When undefined, opcode 6 is a NOP and
//                    zero_flag_i is ignored.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   mcu_en_i       core enable (shared with fetch)
//   inst_in_i      instruction word, [19:16] opcode, [15:0] operand
//   zero_flag_i    datapath zero flag (JZ only)
//   call_en_o      1-cycle call request, target on call_const_o
//   return_en_o    1-cycle return request
//   jmp_en_o       1-cycle jump request, target on jmp_const_o
//   pc_hold_o      freeze fetch PC
//   exe_valid_o    registered issue strobe, with exe_op_o / exe_operand_o
//   depth_o        current call depth, 0..STACK_DEPTH
//   halted_o       core halted
//   stack_err_o    sticky call/return depth error
//
// States:
//   state | meaning
//   IDLE  | core disabled, all outputs low
//   FLUSH | start-up or branch-shadow slot, instruction word ignored
//   RUN   | decode instruction word
//   WAIT  | stalled on WAIT, counting down
//   HALT  | halted until mcu_en_i drops
// ---------------------------------------------------------------------------
module inst_decoder #(
    parameter int STACK_DEPTH = 3,
    parameter int WAIT_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mcu_en_i,
    input  logic [19:0] inst_in_i,
    input  logic        zero_flag_i,
    output logic        call_en_o,
    output logic [15:0] call_const_o,
    output logic        return_en_o,
    output logic        jmp_en_o,
    output logic [15:0] jmp_const_o,
    output logic        pc_hold_o,
    output logic        exe_valid_o,
    output logic [3:0]  exe_op_o,
    output logic [15:0] exe_operand_o,
    output logic [1:0]  depth_o,
    output logic        halted_o,
    output logic        stack_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_RUN   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_CALL = 4'h2;
    localparam logic [3:0] OP_RET  = 4'h3;
    localparam logic [3:0] OP_WAIT = 4'h4;
    localparam logic [3:0] OP_HALT = 4'h5;
`ifdef DEC_COND_JMP_EN
    localparam logic [3:0] OP_JZ   = 4'h6;
`endif

    localparam logic [1:0] DEPTH_MAX = 2'(STACK_DEPTH);

    state_t              state_q, state_d;
    logic [1:0]          depth_q, depth_d;
    logic                err_q, err_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                exe_valid_q, exe_valid_d;
    logic [3:0]          exe_op_q, exe_op_d;
    logic [15:0]         exe_operand_q, exe_operand_d;

    logic [3:0]          opcode;
    logic [15:0]         operand;
    logic [WAIT_W-1:0]   wait_n;

    assign opcode  = inst_in_i[19:16];
    assign operand = inst_in_i[15:0];
    assign wait_n  = operand[WAIT_W-1:0];

`ifndef DEC_COND_JMP_EN
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            depth_q       <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            exe_valid_q   <= 1'b0;
            exe_op_q      <= '0;
            exe_operand_q <= '0;
        end else begin
            state_q       <= state_d;
            depth_q       <= depth_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
            exe_valid_q   <= exe_valid_d;
            exe_op_q      <= exe_op_d;
            exe_operand_q <= exe_operand_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        depth_d       = depth_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        exe_valid_d   = 1'b0;
        exe_op_d      = '0;
        exe_operand_d = '0;
        call_en_o     = 1'b0;
        call_const_o  = '0;
        return_en_o   = 1'b0;
        jmp_en_o      = 1'b0;
        jmp_const_o   = '0;
        pc_hold_o     = 1'b0;

        if (!mcu_en_i) begin
            // Disabling the core is the only exit from HALT and wipes all
            // tracking state; HALT keeps fetch frozen until the edge.
            state_d = ST_IDLE;
            depth_d = '0;
            err_d   = 1'b0;
            cnt_d   = '0;
            if (state_q == ST_HALT) begin
                pc_hold_o = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Fetch loads the start PC on this edge.
                    state_d = ST_FLUSH;
                end
                ST_FLUSH: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    case (opcode)
                        OP_JMP: begin
                            jmp_en_o    = 1'b1;
                            jmp_const_o = operand;
                            state_d     = ST_FLUSH;
                        end
                        OP_CALL: begin
                            if (depth_q < DEPTH_MAX) begin
                                call_en_o    = 1'b1;
                                call_const_o = operand;
                                depth_d      = depth_q + 2'd1;
                                state_d      = ST_FLUSH;
                            end else begin
                                pc_hold_o = 1'b1;
                                err_d     = 1'b1;
                                state_d   = ST_HALT;
                            end
                        end
                        OP_RET: begin
                            if (depth_q != 2'd0) begin
                                return_en_o = 1'b1;
                                depth_d     = depth_q - 2'd1;
                                state_d     = ST_FLUSH;
                            end else begin
                                pc_hold_o = 1'b1;
                                err_d     = 1'b1;
                                state_d   = ST_HALT;
                            end
                        end
                        OP_WAIT: begin
                            // Counter holds the remaining extra hold cycles,
                            // so the next word is decoded n+1 cycles later.
                            if (wait_n != '0) begin
                                pc_hold_o = 1'b1;
                                cnt_d     = wait_n - WAIT_W'(1);
                                state_d   = ST_WAIT;
                            end
                        end
                        OP_HALT: begin
                            pc_hold_o = 1'b1;
                            state_d   = ST_HALT;
                        end
`ifdef DEC_COND_JMP_EN
                        OP_JZ: begin
                            if (zero_flag_i) begin
                                jmp_en_o    = 1'b1;
                                jmp_const_o = operand;
                                state_d     = ST_FLUSH;
                            end
                        end
`endif
                        default: begin
                            // NOP, reserved and (undefined build) JZ fall here.
                            if (opcode[3]) begin
                                exe_valid_d   = 1'b1;
                                exe_op_d      = opcode;
                                exe_operand_d = operand;
                            end
                        end
                    endcase
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        pc_hold_o = 1'b1;
                        cnt_d     = cnt_q - WAIT_W'(1);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    pc_hold_o = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign halted_o      = (state_q == ST_HALT);
    assign stack_err_o   = err_q;
    assign depth_o       = depth_q;
    assign exe_valid_o   = exe_valid_q;
    assign exe_op_o      = exe_op_q;
    assign exe_operand_o = exe_operand_q;

endmodule
